// File: rtl/census_frame_ctrl.sv
// census_frame_ctrl: frame sequencer for census3x3.
// Paces pixels into the core, tags results, ends on count or timeout.
module census_frame_ctrl #(
  parameter int IMAGE_WIDTH  = 320,
  parameter int IMAGE_HEIGHT = 240,
  parameter int GAP_CYCLES   = 3,
  parameter int TIMEOUT      = 300000,
  parameter int CNT_W        = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             timeout_err,
  input  logic             src_valid,
  input  logic [7:0]       src_data,
  output logic             src_ready,
  output logic             gray_valid,
  output logic [7:0]       gray,
  input  logic             census_valid,
  input  logic [15:0]      census_in,
  output logic             out_valid,
  output logic [15:0]      out_data,
  output logic [CNT_W-1:0] out_row,
  output logic [CNT_W-1:0] out_col,
  output logic [CNT_W-1:0] out_cnt
);

  localparam int NPIX =
    IMAGE_WIDTH * IMAGE_HEIGHT;

  localparam int GAP_W =
    (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam int TMO_W =
    (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [CNT_W-1:0] NPIX_C =
    CNT_W'(NPIX);

  localparam logic [CNT_W-1:0] LAST_PIX =
    CNT_W'(NPIX - 1);

  localparam logic [CNT_W-1:0] LAST_COL =
    CNT_W'(IMAGE_WIDTH - 1);

  localparam logic [GAP_W-1:0] GAP_LAST =
    GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  localparam logic [TMO_W-1:0] TMO_LAST =
    TMO_W'(TIMEOUT - 1);

  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);
  localparam logic [GAP_W-1:0] G_ONE = GAP_W'(1);
  localparam logic [TMO_W-1:0] T_ONE = TMO_W'(1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FEED  = 3'd1;
  localparam logic [2:0] S_GAP   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]       state;
  logic [2:0]       state_n;
  logic [CNT_W-1:0] pix_cnt;
  logic [CNT_W-1:0] row_cnt;
  logic [CNT_W-1:0] col_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [TMO_W-1:0] tmo_cnt;

  logic st_idle;
  logic st_feed;
  logic st_gap;
  logic st_drain;
  logic st_done;
  logic accept;
  logic go;
  logic last_pix;
  logic capture;
  logic frame_full;
  logic tmo_hit;
  logic gap_end;

  assign st_idle  = (state == S_IDLE);
  assign st_feed  = (state == S_FEED);
  assign st_gap   = (state == S_GAP);
  assign st_drain = (state == S_DRAIN);
  assign st_done  = (state == S_DONE);

  assign src_ready = st_feed;
  assign busy      = st_feed | st_gap | st_drain;
  assign done      = st_done;

  assign accept   = src_valid & src_ready;
  assign go       = st_idle & start;
  assign last_pix = (pix_cnt == LAST_PIX);

  assign frame_full = (out_cnt == NPIX_C);
  assign tmo_hit    = (tmo_cnt == TMO_LAST);
  assign gap_end    = (gap_cnt == GAP_LAST);

  assign capture = busy
                 & census_valid
                 & (out_cnt < NPIX_C);

  // Next-state decode for the frame sequencer.
  always_comb begin
    state_n = state;
    unique case (1'b1)
      st_idle: begin
        if (start)
          state_n = S_FEED;
      end
      st_feed: begin
        if (accept) begin
          if (last_pix)
            state_n = S_DRAIN;
          else if (GAP_CYCLES > 0)
            state_n = S_GAP;
          else
            state_n = S_FEED;
        end
      end
      st_gap: begin
        if (gap_end)
          state_n = S_FEED;
      end
      st_drain: begin
        if (frame_full)
          state_n = S_DONE;
        else if (!capture && tmo_hit)
          state_n = S_DONE;
      end
      st_done: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst)
      state <= S_IDLE;
    else
      state <= state_n;
  end

  // Pixel feed: register accepted pixel, one-cycle strobe.
  always_ff @(posedge clk) begin
    if (!rst) begin
      gray_valid <= 1'b0;
      gray       <= '0;
      pix_cnt    <= '0;
    end else begin
      gray_valid <= accept;
      if (accept) begin
        gray    <= src_data;
        pix_cnt <= pix_cnt + C_ONE;
      end else if (go) begin
        pix_cnt <= '0;
      end
    end
  end

  // Idle spacing between fed pixels.
  always_ff @(posedge clk) begin
    if (!rst) begin
      gap_cnt <= '0;
    end else if (st_gap) begin
      if (gap_end)
        gap_cnt <= '0;
      else
        gap_cnt <= gap_cnt + G_ONE;
    end else begin
      gap_cnt <= '0;
    end
  end

  // Result capture with raster row/col tagging.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_row   <= '0;
      out_col   <= '0;
      out_cnt   <= '0;
      row_cnt   <= '0;
      col_cnt   <= '0;
    end else begin
      out_valid <= capture;
      if (go) begin
        out_cnt <= '0;
        row_cnt <= '0;
        col_cnt <= '0;
      end else if (capture) begin
        out_data <= census_in;
        out_row  <= row_cnt;
        out_col  <= col_cnt;
        out_cnt  <= out_cnt + C_ONE;
        if (col_cnt == LAST_COL) begin
          col_cnt <= '0;
          row_cnt <= row_cnt + C_ONE;
        end else begin
          col_cnt <= col_cnt + C_ONE;
        end
      end
    end
  end

  // Drain watchdog; a capture restarts the window.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (go)
        timeout_err <= 1'b0;
      if (st_drain) begin
        if (capture) begin
          tmo_cnt <= '0;
        end else if (tmo_hit) begin
          tmo_cnt <= '0;
          if (!frame_full)
            timeout_err <= 1'b1;
        end else begin
          tmo_cnt <= tmo_cnt + T_ONE;
        end
      end else begin
        tmo_cnt <= '0;
      end
    end
  end

endmodule
